jam_detector: RTL and testbench

Upstream conditioning stage for traffic_system_top. It turns raw per-lane vehicle-loop levels (arrival loop at the queue tail, departure loop at the stop line) into the four jam_sensor_0..3 inputs that the controller consumes. Each lane does three things: synchronise the loop inputs, detect rising edges, and keep a saturating queue-occupancy counter. A per-lane FSM then asserts jam with a persistence filter and hysteresis. All four lanes are identical and independent.

---
 rtl/jam_detector.sv | 155 +++++++++++++++
 tb/tb_jam_detector.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_detector.sv
`default_nettype none
// ============================================================================
// jam_detector : per-lane loop synchroniser, edge detect, saturating queue
//                occupancy counter and persistence/hysteresis jam FSM.
// Revision     : 1.0
// ============================================================================
module jam_detector #(
   parameter int CNT_W   = 6,
   parameter int JAM_ON  = 20,
   parameter int JAM_OFF = 8,
   parameter int HOLD    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arrive_loop_0,
   input  logic             arrive_loop_1,
   input  logic             arrive_loop_2,
   input  logic             arrive_loop_3,
   input  logic             depart_loop_0,
   input  logic             depart_loop_1,
   input  logic             depart_loop_2,
   input  logic             depart_loop_3,
   output logic             jam_sensor_0,
   output logic             jam_sensor_1,
   output logic             jam_sensor_2,
   output logic             jam_sensor_3,
   output logic [CNT_W-1:0] q_count_0,
   output logic [CNT_W-1:0] q_count_1,
   output logic [CNT_W-1:0] q_count_2,
   output logic [CNT_W-1:0] q_count_3
);

   localparam int                  c_LANES    = 4;
   localparam int                  c_HOLD_W   = $clog2(HOLD + 1);
   localparam logic [CNT_W-1:0]    c_Q_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]    c_Q_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]    c_JAM_ON   = CNT_W'(JAM_ON);
   localparam logic [CNT_W-1:0]    c_JAM_OFF  = CNT_W'(JAM_OFF);
   localparam logic [c_HOLD_W-1:0] c_HOLD     = c_HOLD_W'(HOLD);
   localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);

   typedef enum logic [1:0] {
      S_CLEAR   = 2'd0,
      S_PENDING = 2'd1,
      S_JAM     = 2'd2
   } state_t;

   logic [c_LANES-1:0]            w_arrive;
   logic [c_LANES-1:0]            w_depart;
   logic [c_LANES-1:0]            w_jam;
   logic [c_LANES-1:0][CNT_W-1:0] w_qcnt;

   assign w_arrive = {arrive_loop_3, arrive_loop_2, arrive_loop_1, arrive_loop_0};
   assign w_depart = {depart_loop_3, depart_loop_2, depart_loop_1, depart_loop_0};

   for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
      logic                r_arr_s1, r_arr_s2, r_arr_s3;
      logic                r_dep_s1, r_dep_s2, r_dep_s3;
      logic                w_arr_ev, w_dep_ev;
      logic [CNT_W-1:0]    r_qcnt;
      state_t              r_state;
      logic [c_HOLD_W-1:0] r_hold;
      logic                r_jam;

      // Two-flop synchroniser plus history flop; history clears on reset so a
      // loop held high across reset still yields exactly one event.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_arr_s1 <= 1'b0;
            r_arr_s2 <= 1'b0;
            r_arr_s3 <= 1'b0;
            r_dep_s1 <= 1'b0;
            r_dep_s2 <= 1'b0;
            r_dep_s3 <= 1'b0;
         end else begin
            r_arr_s1 <= w_arrive[gi];
            r_arr_s2 <= r_arr_s1;
            r_arr_s3 <= r_arr_s2;
            r_dep_s1 <= w_depart[gi];
            r_dep_s2 <= r_dep_s1;
            r_dep_s3 <= r_dep_s2;
         end
      end

      assign w_arr_ev = r_arr_s2 & ~r_arr_s3;
      assign w_dep_ev = r_dep_s2 & ~r_dep_s3;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_qcnt <= '0;
         end else if (w_arr_ev && !w_dep_ev && (r_qcnt != c_Q_MAX)) begin
            r_qcnt <= r_qcnt + c_Q_ONE;
         end else if (w_dep_ev && !w_arr_ev && (r_qcnt != '0)) begin
            r_qcnt <= r_qcnt - c_Q_ONE;
         end
      end

      // PENDING counts consecutive edges at or above JAM_ON; JAM only
      // releases once occupancy has fallen to JAM_OFF.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_state <= S_CLEAR;
            r_hold  <= '0;
            r_jam   <= 1'b0;
         end else begin
            case (r_state)
               S_CLEAR: begin
                  if (r_qcnt >= c_JAM_ON) begin
                     r_state <= S_PENDING;
                     r_hold  <= c_HOLD_ONE;
                  end
               end
               S_PENDING: begin
                  if (r_qcnt < c_JAM_ON) begin
                     r_state <= S_CLEAR;
                     r_hold  <= '0;
                  end else if (r_hold == c_HOLD) begin
                     r_state <= S_JAM;
                     r_jam   <= 1'b1;
                  end else begin
                     r_hold <= r_hold + c_HOLD_ONE;
                  end
               end
               S_JAM: begin
                  if (r_qcnt <= c_JAM_OFF) begin
                     r_state <= S_CLEAR;
                     r_hold  <= '0;
                     r_jam   <= 1'b0;
                  end
               end
               default: begin
                  r_state <= S_CLEAR;
                  r_hold  <= '0;
                  r_jam   <= 1'b0;
               end
            endcase
         end
      end

      assign w_jam[gi]  = r_jam;
      assign w_qcnt[gi] = r_qcnt;
   end

   assign jam_sensor_0 = w_jam[0];
   assign jam_sensor_1 = w_jam[1];
   assign jam_sensor_2 = w_jam[2];
   assign jam_sensor_3 = w_jam[3];

   assign q_count_0 = w_qcnt[0];
   assign q_count_1 = w_qcnt[1];
   assign q_count_2 = w_qcnt[2];
   assign q_count_3 = w_qcnt[3];

endmodule
`default_nettype wire

// File: tb/tb_jam_detector.sv
`default_nettype none
// ============================================================================
// tb_jam_detector : directed + randomized stimulus, scoreboard against a
//                   queue-occupancy reference model.
// Revision        : 1.0
// ============================================================================
module tb_jam_detector;

   localparam int CNT_W   = 6;
   localparam int JAM_ON  = 20;
   localparam int JAM_OFF = 8;
   localparam int HOLD    = 4;
   localparam int Q_MAX   = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [3:0]            arr;
   logic [3:0]            dep;
   logic [3:0]            dut_jam;
   logic [3:0][CNT_W-1:0] dut_q;

   typedef struct packed {
      logic [3:0]            jam;
      logic [3:0][CNT_W-1:0] q;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_cycle  = 0;

   // Reference model state: occupancy, run length of edges at/above JAM_ON,
   // jam flag, last raw sample and a two-edge delay line of loop rising edges.
   int       m_q[4];
   int       m_run[4];
   bit       m_jam[4];
   bit       m_pa[4];
   bit       m_pd[4];
   bit [1:0] m_ea[4];
   bit [1:0] m_ed[4];

   logic [3:0] cur_a;
   logic [3:0] cur_d;

   always #5 clk = ~clk;

   jam_detector #(
      .CNT_W  (CNT_W),
      .JAM_ON (JAM_ON),
      .JAM_OFF(JAM_OFF),
      .HOLD   (HOLD)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arrive_loop_0(arr[0]),
      .arrive_loop_1(arr[1]),
      .arrive_loop_2(arr[2]),
      .arrive_loop_3(arr[3]),
      .depart_loop_0(dep[0]),
      .depart_loop_1(dep[1]),
      .depart_loop_2(dep[2]),
      .depart_loop_3(dep[3]),
      .jam_sensor_0 (dut_jam[0]),
      .jam_sensor_1 (dut_jam[1]),
      .jam_sensor_2 (dut_jam[2]),
      .jam_sensor_3 (dut_jam[3]),
      .q_count_0    (dut_q[0]),
      .q_count_1    (dut_q[1]),
      .q_count_2    (dut_q[2]),
      .q_count_3    (dut_q[3])
   );

   task automatic check(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, n_cycle, act, req);
      end
   endtask

   task automatic model_edge(input logic [3:0] a, input logic [3:0] d, input logic r);
      exp_t e;
      for (int l = 0; l < 4; l++) begin
         if (!r) begin
            m_q[l]   = 0;
            m_run[l] = 0;
            m_jam[l] = 1'b0;
            m_pa[l]  = 1'b0;
            m_pd[l]  = 1'b0;
            m_ea[l]  = 2'b00;
            m_ed[l]  = 2'b00;
         end else begin
            bit jn;
            jn = m_jam[l] ? (m_q[l] > JAM_OFF) : (m_run[l] > HOLD);
            m_q[l] = m_q[l] + int'(m_ea[l][1]) - int'(m_ed[l][1]);
            if (m_q[l] > Q_MAX) m_q[l] = Q_MAX;
            if (m_q[l] < 0)     m_q[l] = 0;
            m_run[l] = (m_q[l] >= JAM_ON) ? m_run[l] + 1 : 0;
            m_jam[l] = jn;
            m_ea[l]  = {m_ea[l][0], bit'(a[l] & ~m_pa[l])};
            m_ed[l]  = {m_ed[l][0], bit'(d[l] & ~m_pd[l])};
            m_pa[l]  = a[l];
            m_pd[l]  = d[l];
         end
         e.jam[l] = m_jam[l];
         e.q[l]   = CNT_W'(m_q[l]);
      end
      exp_q.push_back(e);
   endtask

   // Drives inputs for the next rising edge and queues the expected outcome.
   task automatic step(input logic [3:0] a, input logic [3:0] d, input logic r);
      @(negedge clk);
      #1;
      arr   = a;
      dep   = d;
      rst_n = r;
      model_edge(a, d, r);
   endtask

   task automatic peek();
      @(posedge clk);
      #4;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'h0, 4'h0, 1'b1);
   endtask

   task automatic pulse(input logic [3:0] a, input logic [3:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         step(a, d, 1'b1);
         step(a, d, 1'b1);
         step(4'h0, 4'h0, 1'b1);
         step(4'h0, 4'h0, 1'b1);
      end
   endtask

   // Monitor: every cycle is an output cycle; compare after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         n_cycle++;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int l = 0; l < 4; l++) begin
               check($sformatf("sb_jam_sensor_%0d", l), int'(dut_jam[l]), int'(e.jam[l]));
               check($sformatf("sb_q_count_%0d", l), int'(dut_q[l]), int'(e.q[l]));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached after %0d cycles", n_cycle);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      arr   = 4'h0;
      dep   = 4'h0;

      // Reset held while loops toggle
      step(4'hF, 4'h0, 1'b0);
      step(4'h0, 4'hF, 1'b0);
      step(4'hF, 4'hF, 1'b0);
      step(4'h0, 4'h0, 1'b1);
      peek();
      for (int l = 0; l < 4; l++) begin
         check("reset_jam", int'(dut_jam[l]), 0);
         check("reset_q", int'(dut_q[l]), 0);
      end

      // Persistence on lane 1
      pulse(4'b0010, 4'b0000, 20);
      idle(3);
      peek();
      check("l1_q_at_20", int'(dut_q[1]), 20);
      check("l1_jam_before_hold", int'(dut_jam[1]), 0);
      idle(1);
      peek();
      check("l1_jam_after_hold", int'(dut_jam[1]), 1);
      check("other_lanes_quiet", int'(dut_jam & 4'b1101), 0);

      // Hysteresis on lane 1
      pulse(4'b0000, 4'b0010, 11);
      idle(1);
      peek();
      check("l1_q_at_9", int'(dut_q[1]), 9);
      check("l1_jam_held_at_9", int'(dut_jam[1]), 1);
      pulse(4'b0000, 4'b0010, 1);
      peek();
      check("l1_q_at_8", int'(dut_q[1]), 8);
      check("l1_jam_cleared", int'(dut_jam[1]), 0);

      // Glitch rejection on lane 2
      pulse(4'b0100, 4'b0000, 20);
      pulse(4'b0000, 4'b0100, 1);
      idle(1);
      peek();
      check("l2_q_at_19", int'(dut_q[2]), 19);
      check("l2_no_jam_glitch", int'(dut_jam[2]), 0);
      pulse(4'b0100, 4'b0000, 1);
      idle(3);
      peek();
      check("l2_jam_restarted_wait", int'(dut_jam[2]), 0);
      idle(1);
      peek();
      check("l2_jam_after_full_wait", int'(dut_jam[2]), 1);

      // Boundaries on lane 3
      pulse(4'b1000, 4'b0000, 70);
      idle(1);
      peek();
      check("l3_saturate", int'(dut_q[3]), Q_MAX);
      pulse(4'b1000, 4'b1000, 3);
      idle(1);
      peek();
      check("l3_aligned_at_max", int'(dut_q[3]), Q_MAX);
      pulse(4'b0000, 4'b1000, 70);
      idle(1);
      peek();
      check("l3_floor", int'(dut_q[3]), 0);
      pulse(4'b1000, 4'b1000, 2);
      pulse(4'b0000, 4'b1000, 3);
      idle(1);
      peek();
      check("l3_stays_zero", int'(dut_q[3]), 0);

      // Reset in the middle of a jam, lane 0 loop held high across it
      pulse(4'b0010, 4'b0000, 12);
      idle(6);
      peek();
      check("l1_rejammed", int'(dut_jam[1]), 1);
      step(4'b0001, 4'b0000, 1'b1);
      step(4'b0001, 4'b0000, 1'b1);
      step(4'b0001, 4'b0000, 1'b0);
      peek();
      check("midreset_l1_jam", int'(dut_jam[1]), 0);
      check("midreset_l1_q", int'(dut_q[1]), 0);
      check("midreset_l2_jam", int'(dut_jam[2]), 0);
      for (int i = 0; i < 3; i++) step(4'b0001, 4'b0000, 1'b1);
      peek();
      check("held_loop_one_event", int'(dut_q[0]), 1);
      for (int i = 0; i < 4; i++) step(4'b0001, 4'b0000, 1'b1);
      peek();
      check("held_loop_no_repeat", int'(dut_q[0]), 1);

      // Randomized phases with per-lane arrival/departure activity bias
      cur_a = 4'h0;
      cur_d = 4'h0;
      for (int ph = 0; ph < 8; ph++) begin
         int pa[4];
         int pd[4];
         for (int l = 0; l < 4; l++) begin
            pa[l] = int'($urandom_range(2, 8));
            pd[l] = int'($urandom_range(0, 7));
         end
         for (int c = 0; c < 500; c++) begin
            for (int l = 0; l < 4; l++) begin
               if (int'($urandom_range(0, 15)) < pa[l]) cur_a[l] = ~cur_a[l];
               if (int'($urandom_range(0, 15)) < pd[l]) cur_d[l] = ~cur_d[l];
            end
            step(cur_a, cur_d, ($urandom_range(0, 999) != 0));
         end
      end

      idle(2);
      @(posedge clk);
      #4;
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
